// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer
//   Receive side of the inter-layer word stream. Collects N_PARALLEL serial
//   DATA_WIDTH words from a valid/ready stream and presents them as one
//   parallel vector behind a single valid/ready handshake. Word k of a frame
//   lands in o_data[k*DATA_WIDTH +: DATA_WIDTH].
//
// Ports
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous active-high reset
//   i_data   : serial input word
//   i_valid  : i_data valid
//   i_last   : last word of frame (checked only when USE_LAST=1)
//   o_ready  : a word is accepted this cycle when i_valid is also high
//   o_data   : parallel frame
//   o_valid  : o_data holds a complete frame
//   i_ready  : downstream accepts o_data
//   o_err    : one-cycle framing-error pulse (always 0 when USE_LAST=0)
// ---------------------------------------------------------------------------
module deserializer #(
    parameter int N_PARALLEL = 10,
    parameter int DATA_WIDTH = 16,
    parameter int USE_LAST   = 0
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [DATA_WIDTH-1:0]            i_data,
    input  logic                             i_valid,
    input  logic                             i_last,
    output logic                             o_ready,
    output logic [N_PARALLEL*DATA_WIDTH-1:0] o_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_err
);

    localparam int CNT_W = (N_PARALLEL > 1) ? $clog2(N_PARALLEL) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PARALLEL - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next, wr_pos;
    logic             accept, drain, last_seen, err_next;

    assign o_valid   = (state == HOLD);
    // In HOLD the input side is only open when the held frame drains in the
    // same cycle, so a new word can start the next frame without a bubble.
    assign o_ready   = (state == FILL) || i_ready;
    assign accept    = i_valid && o_ready;
    assign drain     = o_valid && i_ready;
    assign last_seen = (USE_LAST != 0) && i_last;

    always_comb begin
        state_next = state;
        count_next = count;
        err_next   = 1'b0;
        // A word accepted in HOLD is always the first word of the next frame.
        wr_pos     = (state == HOLD) ? '0 : count;
        if (accept) begin
            if (wr_pos == LAST_IDX) begin
                // Frame completes even when i_last is missing; flag it.
                state_next = HOLD;
                count_next = '0;
                err_next   = (USE_LAST != 0) && !i_last;
            end else if (last_seen) begin
                // Early i_last: discard the partial frame and restart.
                state_next = FILL;
                count_next = '0;
                err_next   = 1'b1;
            end else begin
                state_next = FILL;
                count_next = wr_pos + 1'b1;
            end
        end else if (drain) begin
            state_next = FILL;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= FILL;
            count <= '0;
            o_err <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            o_err <= err_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data <= '0;
        end else if (accept) begin
            for (int k = 0; k < N_PARALLEL; k++) begin
                if (wr_pos == CNT_W'(k)) begin
                    o_data[k*DATA_WIDTH +: DATA_WIDTH] <= i_data;
                end
            end
        end
    end

endmodule
